// File: rtl/dct_pkg.sv
// Shared constants for the 2D 8x8 DCT datapath: transform size, index
// and sample widths, and the Q14 cosine table used by the 1D DCT stages.
package dct_pkg;

  localparam int DCT_N      = 8;
  localparam int DCT_IDX_W  = 3;
  localparam int DCT_IN_W   = 8;
  localparam int DCT_COEF_W = 16;

  // cos(k*pi/16) scaled by 2^14, k = 0..7
  localparam logic signed [15:0] DCT_C0_Q14 = 16'sd16384;
  localparam logic signed [15:0] DCT_C1_Q14 = 16'sd16069;
  localparam logic signed [15:0] DCT_C2_Q14 = 16'sd15137;
  localparam logic signed [15:0] DCT_C3_Q14 = 16'sd13623;
  localparam logic signed [15:0] DCT_C4_Q14 = 16'sd11585;
  localparam logic signed [15:0] DCT_C5_Q14 = 16'sd9102;
  localparam logic signed [15:0] DCT_C6_Q14 = 16'sd6270;
  localparam logic signed [15:0] DCT_C7_Q14 = 16'sd3196;

endpackage

// File: rtl/dct_tpose_ram.sv
// Simple dual-port storage for the transpose buffer: one write port and one
// registered read port. The read register only updates when i_re is high,
// so a stalled consumer keeps seeing the same word.
module dct_tpose_ram
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = DCT_COEF_W,
  parameter int ADDR_W     = 7
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_W-1:0]     i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [ADDR_W-1:0]     i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_W];
  logic [DATA_WIDTH-1:0] r_rdata;

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Registered read, held while i_re is low
  always_ff @(posedge clk) begin
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose buffer between the row and column DCT passes.
// Rows are written row-major into the current write bank; completed banks are
// read back column-major over a valid/ready port. A block arriving while its
// target bank is still full is dropped whole and flagged in overflow.
module dct_transpose_buffer
  import dct_pkg::*;
#(
  parameter int DATA_WIDTH = DCT_COEF_W,
  parameter int N          = DCT_N
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_coef,
  input  logic [DCT_IDX_W-1:0]  in_index,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [DCT_IDX_W-1:0]  out_index,
  output logic                  out_last,
  output logic                  out_block_last,
  output logic                  overflow,
  input  logic                  clear_overflow
);

  localparam int ADDR_W = 1 + 2 * $clog2(N);
  localparam int CNT_W  = 2 * DCT_IDX_W;
  localparam logic [DCT_IDX_W-1:0] LAST_IDX = DCT_IDX_W'(N - 1);

  // Write side state
  logic                 r_wr_bank;
  logic [DCT_IDX_W-1:0] r_wr_row;
  logic                 r_started;    // a sample of the current block was seen
  logic                 r_drop;       // current block is being discarded
  logic                 r_set_pend;   // completed bank becomes readable next edge
  logic                 r_set_bank;
  logic [1:0]           r_bank_full;
  logic                 r_overflow;

  // Read side state
  logic                 r_rd_bank;
  logic [CNT_W-1:0]     r_rd_cnt;     // {col, row} of the next read to issue
  logic                 r_rd_done;    // all 64 reads issued, waiting on the last transfer
  logic                 r_out_valid;
  logic [DCT_IDX_W-1:0] r_out_index;
  logic                 r_out_last;
  logic                 r_out_block_last;

  logic                 w_blk_first;
  logic                 w_drop_new;
  logic                 w_drop;
  logic                 w_we;
  logic                 w_row_end;
  logic                 w_blk_end;
  logic                 w_blk_commit;
  logic                 w_xfer;
  logic                 w_release;
  logic                 w_rd_en;
  logic [DCT_IDX_W-1:0] w_rd_row;
  logic [DCT_IDX_W-1:0] w_rd_col;
  logic [ADDR_W-1:0]    w_waddr;
  logic [ADDR_W-1:0]    w_raddr;
  logic [DATA_WIDTH-1:0] w_ram_q;
  logic [1:0]           w_bank_full_next;

  // The drop decision is taken on the first sample of a block and then
  // held for the remaining rows of that block.
  assign w_blk_first  = in_valid && !r_started && (r_wr_row == '0);
  assign w_drop_new   = w_blk_first && r_bank_full[r_wr_bank];
  assign w_drop       = r_started ? r_drop : r_bank_full[r_wr_bank];
  assign w_we         = in_valid && !w_drop;
  assign w_row_end    = in_valid && in_last;
  assign w_blk_end    = w_row_end && (r_wr_row == LAST_IDX);
  assign w_blk_commit = w_blk_end && !w_drop;

  assign w_xfer    = r_out_valid && out_ready;
  assign w_release = w_xfer && r_out_block_last;
  assign w_rd_row  = r_rd_cnt[DCT_IDX_W-1:0];
  assign w_rd_col  = r_rd_cnt[CNT_W-1:DCT_IDX_W];
  assign w_rd_en   = r_bank_full[r_rd_bank] && !r_rd_done && (!r_out_valid || out_ready);

  assign w_waddr = {r_wr_bank, r_wr_row, in_index};
  assign w_raddr = {r_rd_bank, w_rd_row, w_rd_col};

  // Per-bank occupancy: set one edge after the block completes, cleared when
  // its last sample is handed downstream. The two events never hit one bank.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    assign w_bank_full_next[gi] = (r_set_pend && (r_set_bank == 1'(gi))) ||
                                  (r_bank_full[gi] && !(w_release && (r_rd_bank == 1'(gi))));
  end

  dct_tpose_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (in_coef),
    .i_re    (w_rd_en),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_q)
  );

  // Write pointer, per-block drop flag and bank hand-off
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_bank  <= 1'b0;
      r_wr_row   <= '0;
      r_started  <= 1'b0;
      r_drop     <= 1'b0;
      r_set_pend <= 1'b0;
      r_set_bank <= 1'b0;
    end else begin
      r_set_pend <= w_blk_commit;
      if (w_blk_commit) r_set_bank <= r_wr_bank;
      if (in_valid) r_started <= 1'b1;
      if (w_blk_first) r_drop <= w_drop_new;
      if (w_row_end) begin
        if (r_wr_row == LAST_IDX) begin
          r_wr_row  <= '0;
          r_started <= 1'b0;
          r_drop    <= 1'b0;
          if (!w_drop) r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_row <= r_wr_row + DCT_IDX_W'(1);
        end
      end
    end
  end

  // Bank occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_bank_full <= 2'b00;
    else        r_bank_full <= w_bank_full_next;
  end

  // Sticky overflow; a new drop wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              r_overflow <= 1'b0;
    else if (w_drop_new)     r_overflow <= 1'b1;
    else if (clear_overflow) r_overflow <= 1'b0;
  end

  // Column-major read sequencing and output register control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_bank        <= 1'b0;
      r_rd_cnt         <= '0;
      r_rd_done        <= 1'b0;
      r_out_valid      <= 1'b0;
      r_out_index      <= '0;
      r_out_last       <= 1'b0;
      r_out_block_last <= 1'b0;
    end else begin
      if (w_rd_en) begin
        r_rd_cnt         <= r_rd_cnt + CNT_W'(1);
        r_out_valid      <= 1'b1;
        r_out_index      <= w_rd_row;
        r_out_last       <= (w_rd_row == LAST_IDX);
        r_out_block_last <= (w_rd_row == LAST_IDX) && (w_rd_col == LAST_IDX);
        if ((w_rd_row == LAST_IDX) && (w_rd_col == LAST_IDX)) r_rd_done <= 1'b1;
      end else if (w_xfer) begin
        r_out_valid <= 1'b0;
      end
      if (w_release) begin
        r_rd_bank <= ~r_rd_bank;
        r_rd_done <= 1'b0;
      end
    end
  end

  // RAM output is only meaningful while valid; forcing zero otherwise keeps
  // out_data at 0 from reset without putting a reset on the RAM register.
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_valid ? w_ram_q : '0;
  assign out_index      = r_out_index;
  assign out_last       = r_out_last;
  assign out_block_last = r_out_block_last;
  assign overflow       = r_overflow;

endmodule

// File: tb/tb_dct_transpose_buffer.sv
// Bench for dct_transpose_buffer: blocks of row coefficients are pushed in,
// and a reference model (a per-block 8x8 array, a queue of expected outputs in
// column-major order and a count of blocks held) predicts every transfer.
module tb_dct_transpose_buffer;
  import dct_pkg::*;

  localparam int DW = DCT_COEF_W;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [2:0]    idx;
    logic          last;
    logic          blast;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_coef = '0;
  logic [2:0]    in_index = '0;
  logic          in_last = 1'b0;
  logic          out_ready = 1'b0;
  logic          clear_overflow = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [2:0]    out_index;
  logic          out_last;
  logic          out_block_last;
  logic          overflow;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  int   held = 0;
  logic model_ovf = 1'b0;
  int   n_xfer = 0;
  int   ready_mode = 1;
  int   cyc = 0;
  bit   gap_chk = 1'b0;
  int   prev_xfer_cyc = -100;
  bit   prev_was_blast = 1'b0;
  bit   stalled = 1'b0;
  exp_t hold_v;
  logic [DW-1:0] blk_vals [8][8];

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  dct_transpose_buffer #(.DATA_WIDTH(DW), .N(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_coef        (in_coef),
    .in_index       (in_index),
    .in_last        (in_last),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_index      (out_index),
    .out_last       (out_last),
    .out_block_last (out_block_last),
    .overflow       (overflow),
    .clear_overflow (clear_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Output monitor: runs mid-cycle, so it sees the values that the next
  // rising edge will transfer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_hold", 32'({out_data, out_index, out_last, out_block_last}), 32'(hold_v));
      end
      if (out_valid && out_ready) begin
        chk("xfer_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("data", 32'(out_data), 32'(e.data));
          chk("index", 32'(out_index), 32'(e.idx));
          chk("last", 32'(out_last), 32'(e.last));
          chk("block_last", 32'(out_block_last), 32'(e.blast));
        end
        if (gap_chk && prev_was_blast)
          chk("block_gap_le1", 32'((cyc - prev_xfer_cyc) <= 2), 32'd1);
        prev_xfer_cyc  = cyc;
        prev_was_blast = out_block_last;
        if (out_block_last) held = held - 1;
        n_xfer = n_xfer + 1;
      end
      stalled = out_valid && !out_ready;
      if (stalled) hold_v = '{data: out_data, idx: out_index, last: out_last, blast: out_block_last};
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic fill_pattern(input int base);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        blk_vals[r][c] = DW'(base + r * 8 + c);
  endtask

  task automatic fill_random();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        case ($urandom_range(0, 3))
          0:       blk_vals[r][c] = 16'h8000;
          1:       blk_vals[r][c] = 16'h7fff;
          2:       blk_vals[r][c] = 16'hffff;
          default: blk_vals[r][c] = DW'($urandom);
        endcase
  endtask

  // Sends blk_vals as one block; the model decides acceptance from the number
  // of blocks still held (both banks busy means the block is lost).
  task automatic send_block(input bit perm, input bit gaps, input bit clr_first);
    bit drop = 1'b0;
    int order[8];
    int j, tmp;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) order[k] = k;
      if (perm) begin
        for (int k = 7; k > 0; k--) begin
          j = int'($urandom_range(0, k));
          tmp = order[k]; order[k] = order[j]; order[j] = tmp;
        end
      end
      for (int k = 0; k < 8; k++) begin
        if (gaps && $urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          tick();
        end
        if (r == 0 && k == 0) drop = (held >= 2);
        in_valid       = 1'b1;
        in_index       = 3'(order[k]);
        in_coef        = blk_vals[r][order[k]];
        in_last        = (k == 7);
        clear_overflow = clr_first && (r == 0) && (k == 0);
        tick();
        clear_overflow = 1'b0;
        if (r == 0 && k == 0) begin
          if (drop)           model_ovf = 1'b1;
          else if (clr_first) model_ovf = 1'b0;
          chk("ovf_after_first", 32'(overflow), 32'(model_ovf));
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!drop) begin
      for (int c = 0; c < 8; c++)
        for (int r = 0; r < 8; r++)
          exp_q.push_back('{data: blk_vals[r][c], idx: 3'(r), last: (r == 7), blast: (r == 7 && c == 7)});
      held = held + 1;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      tick();
      t++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
    repeat (4) tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_index"}, 32'(out_index), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_blast"}, 32'(out_block_last), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int t;

    ready_mode = 1;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single block in order, latency to first output
    fill_pattern(0);
    base = n_xfer;
    send_block(1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("latency_edge1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("latency_edge2", 32'(out_valid), 32'd1);
    wait_drain();
    chk("t1_count", 32'(n_xfer - base), 32'd64);

    // Same block with random backpressure
    ready_mode = 2;
    base = n_xfer;
    send_block(1'b0, 1'b0, 1'b0);
    wait_drain();
    chk("t2_count", 32'(n_xfer - base), 32'd64);

    // Two back-to-back blocks, bounded gap between them
    ready_mode = 1;
    tick();
    prev_was_blast = 1'b0;
    gap_chk = 1'b1;
    base = n_xfer;
    fill_pattern(0);
    send_block(1'b0, 1'b0, 1'b0);
    fill_pattern(100);
    send_block(1'b0, 1'b0, 1'b0);
    wait_drain();
    gap_chk = 1'b0;
    chk("t3_count", 32'(n_xfer - base), 32'd128);
    chk("t3_ovf", 32'(overflow), 32'd0);

    // Overflow: downstream stalled, third and fourth blocks dropped
    ready_mode = 0;
    tick();
    base = n_xfer;
    fill_pattern(0);   send_block(1'b0, 1'b0, 1'b0);
    fill_pattern(100); send_block(1'b0, 1'b0, 1'b0);
    chk("t4_ovf_before", 32'(overflow), 32'd0);
    fill_pattern(200); send_block(1'b0, 1'b0, 1'b0);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    model_ovf = 1'b0;
    chk("t4_ovf_cleared", 32'(overflow), 32'd0);
    fill_pattern(300); send_block(1'b0, 1'b0, 1'b1);
    ready_mode = 1;
    tick();
    wait_drain();
    repeat (20) tick();
    chk("t4_count", 32'(n_xfer - base), 32'd128);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    model_ovf = 1'b0;
    chk("t4_ovf_final", 32'(overflow), 32'd0);

    // Permuted indices with extreme signed values
    ready_mode = 2;
    fill_random();
    send_block(1'b1, 1'b0, 1'b0);
    wait_drain();

    // Random blocks, random gaps and backpressure (drops possible)
    for (int b = 0; b < 6; b++) begin
      fill_random();
      send_block(1'b1, 1'b1, 1'b0);
      repeat ($urandom_range(0, 10)) tick();
    end
    wait_drain();
    chk("t7_ovf", 32'(overflow), 32'(model_ovf));
    chk("t7_held", 32'(held), 32'd0);

    // Reset in the middle of a block readout
    ready_mode = 1;
    fill_pattern(0);
    base = n_xfer;
    send_block(1'b0, 1'b0, 1'b0);
    t = 0;
    while (n_xfer < base + 20 && t < 500) begin
      tick();
      t++;
    end
    chk("t6_reached_20", 32'(n_xfer >= base + 20), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    exp_q.delete();
    held = 0;
    model_ovf = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    fill_random();
    base = n_xfer;
    send_block(1'b1, 1'b0, 1'b0);
    wait_drain();
    chk("t6_count", 32'(n_xfer - base), 32'd64);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/dct_transpose_buffer.md
Name: dct_transpose_buffer

Overview:
- Sits between the row-pass 1D DCT and the column-pass 1D DCT of the 2D 8x8 DCT.
- Captures 8 row-transform coefficient streams (row-major) into a ping-pong 8x8 buffer.
- Re-emits each completed block column-major as 8 indexed 8-sample vectors, over a valid/ready interface.
- The input side has no backpressure. When both banks are busy, an incoming block is dropped whole and flagged.

Parameters:
- DATA_WIDTH, 16, width of stored coefficients (input and output, passed through unmodified)
- N, 8, transform size; fixed at 8 (the only supported value)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  input sample strobe
- in_coef  in  DATA_WIDTH  signed row-DCT coefficient
- in_index  in  3  column position of the sample within the current row
- in_last  in  1  last sample of the current row
- out_valid  out  1  output sample available
- out_ready  in  1  downstream accepts sample
- out_data  out  DATA_WIDTH  signed coefficient, column-major order
- out_index  out  3  row position within the column vector (the column DCT's input index)
- out_last  out  1  last sample of a column (out_index==7)
- out_block_last  out  1  last sample of the block (column 7, row 7)
- overflow  out  1  sticky: a block was dropped
- clear_overflow  in  1  synchronous clear of overflow

Behaviour:
- Reset: out_valid, out_data, out_index, out_last, out_block_last and overflow = 0. Both banks are empty; write bank = 0, read bank = 0, all counters = 0.
- Reset asserted mid-operation: the block in flight is discarded with no further output.
- Storage: 2 banks x 64 entries. Address = {bank, row, col}.
- Write side:
  - Every in_valid stores in_coef at [wr_bank][wr_row][in_index]. Samples within a row may arrive in any order.
  - in_valid && in_last: wr_row increments.
  - At wr_row==7 with in_last: wr_row wraps to 0, bank_full[wr_bank] is set, and wr_bank toggles.
  - Duplicate in_index within a row overwrites the earlier sample. Fewer than 8 samples leaves stale entries; no error is flagged.
- Drop rule:
  - On the first in_valid of a block (wr_row==0, no write yet in the row), drop = bank_full[wr_bank], sampled pre-edge.
  - While drop is set: nothing is stored, wr_row still advances on in_last, and bank_full/wr_bank are unchanged.
  - drop clears after row 7's in_last. overflow is set on the drop decision.
  - A bank release on the same cycle as the drop check still causes the drop.
- overflow: stays 1 until clear_overflow. If a new drop and clear_overflow occur in the same cycle, the set wins.
- Read side:
  - When bank_full[rd_bank] is set, samples are emitted for col 0..7 (outer) and row 0..7 (inner).
  - out_data = mem[rd_bank][row][col]; out_index = row.
  - out_last = (row==7); out_block_last = (row==7 && col==7).
- Handshake:
  - A transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, all out_* signals hold stable.
  - out_valid never drops without a transfer.
- Release: on the transfer of out_block_last, bank_full[rd_bank] is cleared and rd_bank toggles.
- Latency: the first out_valid of a block asserts on the 2nd rising edge after the edge that accepts row 7's in_last (one cycle to set bank_full, one registered read).
- Throughput: 1 sample/cycle with out_ready=1. Between consecutive ready blocks, out_valid may deassert for at most 1 cycle.
- Simultaneous events: a bank completing write while the other bank completes read are independent updates; both take effect.
- Arithmetic: none. Data passes bit-exact; sign is preserved.

Decomposition:
- Shared package dct_pkg: DCT_N=8, DCT_IDX_W=3, DCT_IN_W=8, DCT_COEF_W=16, Q14 cosine constants. This block uses DCT_N, DCT_IDX_W and DCT_COEF_W.
- One sub-module, dct_tpose_ram: 128 x DATA_WIDTH simple dual-port, 1 write port, 1 registered read port with read-enable. This allows a read stall without losing data.

Test Plan:
- Single block, in_coef=row*8+col, rows sent in order, out_ready=1 -> out_data 0,8,16..56,1,9..63. out_last on every 8th sample, out_block_last on the 64th only. First out_valid exactly 2 edges after row 7's in_last.
- Same block with out_ready randomly toggled at 50% -> identical 64-sample sequence; out_* stable during every stall; no duplicates or losses.
- Two back-to-back blocks (second block value = 100+row*8+col), out_ready=1 -> 128 correct samples; gap between blocks ≤1 cycle; overflow=0.
- out_ready=0, push 3 blocks -> overflow=1 during block 3's first sample. Release out_ready -> exactly 128 outputs (blocks 1, 2), none from block 3. Pulse clear_overflow -> overflow=0.
- Row samples with in_index permuted (7,0,5,2,...), values -32768, 32767, -1 -> each appears at its correct transposed position, sign intact.
- Assert rst_n low after 20 output transfers -> all outputs 0 asynchronously. Send a new block after reset -> its full 64-sample output is correct from sample 0.
